// File: rtl/aer_token_encoder_pkg.sv
// Shared types for the AER token encoder: FSM states, event record, token indices
// and the 5-bit one-hot line encoding (bit0 Fs, bit1 Zero, bit2 One, bit3 X0, bit4 Fe).
package aer_pkg;

  typedef enum logic [1:0] {IDLE, SET, WAIT_HI, WAIT_LO} state_t;

  typedef struct packed {
    logic chan;
    logic dir;
  } ev_t;

  localparam logic [2:0] TOK_FS  = 3'd0;
  localparam logic [2:0] TOK_SEL = 3'd1;
  localparam logic [2:0] TOK_X0  = 3'd2;
  localparam logic [2:0] TOK_DIR = 3'd3;
  localparam logic [2:0] TOK_FE  = 3'd4;

  localparam int NUM_LINES = 5;

  localparam logic [4:0] LINE_FS   = 5'b00001;
  localparam logic [4:0] LINE_ZERO = 5'b00010;
  localparam logic [4:0] LINE_ONE  = 5'b00100;
  localparam logic [4:0] LINE_X0   = 5'b01000;
  localparam logic [4:0] LINE_FE   = 5'b10000;

  function automatic logic [4:0] tok_line(input logic [2:0] k, input ev_t ev);
    case (k)
      TOK_FS:  tok_line = LINE_FS;
      TOK_SEL: tok_line = ev.chan ? LINE_ONE : LINE_ZERO;
      TOK_X0:  tok_line = LINE_X0;
      TOK_DIR: tok_line = ev.dir ? LINE_ONE : LINE_ZERO;
      default: tok_line = LINE_FE;
    endcase
  endfunction

endpackage

// File: rtl/aer_token_encoder_if.sv
// Event push port plus the five token lines and their acks between encoder and decoder.
interface aer_token_encoder_if;
  logic ev_valid;
  logic ev_ready;
  logic ev_chan;
  logic ev_dir;
  logic Fs, Zero, One, X0, Fe;
  logic Fs_ack, Zero_ack, One_ack, X0_ack, Fe_ack;

  modport master (
    input  ev_valid, ev_chan, ev_dir,
    input  Fs_ack, Zero_ack, One_ack, X0_ack, Fe_ack,
    output ev_ready,
    output Fs, Zero, One, X0, Fe
  );

  modport slave (
    output ev_valid, ev_chan, ev_dir,
    output Fs_ack, Zero_ack, One_ack, X0_ack, Fe_ack,
    input  ev_ready,
    input  Fs, Zero, One, X0, Fe
  );
endinterface

// File: rtl/aer_token_encoder_ack_sync.sv
// Multi-flop synchroniser for one asynchronous ack; latency STAGES cycles, cleared by reset.
module aer_ack_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) sr <= '0;
    else       sr <= {sr[STAGES-2:0], async_in};
  end

  assign sync_out = sr[STAGES-1];

endmodule

// File: rtl/aer_token_encoder.sv
// Queues channel events and sends each as a 5-token return-to-zero frame, one 4-phase handshake per token.
// Optional per-phase watchdog with sticky timeout_err under `AER_TIMEOUT_EN.
module aer_token_encoder
  import aer_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  aer_token_encoder_if.master bus,
  output logic                busy,
  output logic                frame_done
`ifdef AER_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);

  ev_t           mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push;

  state_t        state;
  logic [2:0]    k;
  ev_t           frame;
  logic [4:0]    lines;
  logic [4:0]    ack_raw, ack_sync, cur_mask;
  logic          cur_ack;

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push         = bus.ev_valid && !full;
  assign bus.ev_ready = !full;
  assign busy         = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= '{chan: bus.ev_chan, dir: bus.ev_dir};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (state == IDLE && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign ack_raw = {bus.Fe_ack, bus.X0_ack, bus.One_ack, bus.Zero_ack, bus.Fs_ack};

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_sync
    aer_ack_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (ack_raw[i]),
      .sync_out (ack_sync[i])
    );
  end

  // Only the ack of the line currently being handshaken matters; others are masked off.
  assign cur_mask = tok_line(k, frame);
  assign cur_ack  = |(ack_sync & cur_mask);

`ifdef AER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt;
  logic          waiting, tmo_hit;

  // "waiting" is exactly the condition under which the FSM holds its state.
  assign waiting = (state == WAIT_HI && !cur_ack) || (state == WAIT_LO && cur_ack);
  assign tmo_hit = waiting && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || !waiting) tmo_cnt <= '0;
    else                   tmo_cnt <= tmo_cnt + TW'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      k          <= TOK_FS;
      frame      <= '0;
      lines      <= '0;
      frame_done <= 1'b0;
`ifdef AER_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            frame <= mem[rd_ptr[PW-1:0]];
            k     <= TOK_FS;
            state <= SET;
          end
        end
        SET: begin
          lines <= cur_mask;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (cur_ack) begin
            lines <= '0;
            state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!cur_ack) begin
            if (k == TOK_FE) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              k     <= k + 3'd1;
              state <= SET;
            end
          end
        end
        default: state <= IDLE;
      endcase
`ifdef AER_TIMEOUT_EN
      if (tmo_hit) begin
        lines       <= '0;
        state       <= IDLE;
        timeout_err <= 1'b1;
      end
`endif
    end
  end

  assign bus.Fs   = lines[0];
  assign bus.Zero = lines[1];
  assign bus.One  = lines[2];
  assign bus.X0   = lines[3];
  assign bus.Fe   = lines[4];

endmodule

// File: tb/tb_aer_token_encoder.sv
// Directed bench for aer_token_encoder with a delayed-ack decoder model and token-sequence checker.
module tb_aer_token_encoder;
  import aer_pkg::*;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aer_token_encoder_if bus_if();
  logic busy, frame_done;
`ifdef AER_TIMEOUT_EN
  logic timeout_err;
`endif

  aer_token_encoder #(
    .FIFO_DEPTH     (4),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef AER_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [4:0] lines;
  assign lines = {bus_if.Fe, bus_if.X0, bus_if.One, bus_if.Zero, bus_if.Fs};

  // Decoder model: each ack follows its line 3 clocks later, with per-line enable and force-high.
  logic [4:0] auto_en  = 5'h1f;
  logic [4:0] force_hi = 5'h00;
  logic [2:0] dly [5];
  logic [4:0] dly_out, ack;

  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (reset) dly[i] <= 3'b000;
      else       dly[i] <= {dly[i][1:0], lines[i]};
    end
  end

  always_comb begin
    dly_out = '0;
    for (int i = 0; i < 5; i++) dly_out[i] = dly[i][2];
  end

  assign ack = (auto_en & dly_out) | force_hi;
  assign bus_if.Fs_ack   = ack[0];
  assign bus_if.Zero_ack = ack[1];
  assign bus_if.One_ack  = ack[2];
  assign bus_if.X0_ack   = ack[3];
  assign bus_if.Fe_ack   = ack[4];

  // Token log of rising lines, frame_done counter and the one-hot invariant.
  int tok_q[$];
  int done_cnt = 0;
  bit [4:0] prev_lines = '0;

  always @(posedge clk) begin
    for (int i = 0; i < 5; i++)
      if (lines[i] && !prev_lines[i]) tok_q.push_back(i);
    prev_lines <= lines;
    if (frame_done) done_cnt <= done_cnt + 1;
    if (!reset) check("onehot", 32'($onehot0(lines)), 32'd1);
  end

  int rd_idx = 0;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic c, input logic d);
    bus_if.ev_valid = 1'b1;
    bus_if.ev_chan  = c;
    bus_if.ev_dir   = d;
    @(negedge clk);
    bus_if.ev_valid = 1'b0;
  endtask

  task automatic wait_lines(input string tag, input logic [4:0] tgt, input int budget);
    int n = 0;
    while (lines !== tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(lines), 32'(tgt));
  endtask

  task automatic wait_done(input string tag, input int tgt, input int budget);
    int n = 0;
    while (done_cnt < tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, done_cnt, tgt);
  endtask

  // Token codes are line bit indices: 0 Fs, 1 Zero, 2 One, 3 X0, 4 Fe.
  task automatic check_frame(input string tag, input logic c, input logic d);
    int t [5];
    logic [14:0] got, exp;
    if (tok_q.size() < rd_idx + 5) begin
      check({tag, "_len"}, 32'(tok_q.size() - rd_idx), 32'd5);
      rd_idx = tok_q.size();
      return;
    end
    for (int i = 0; i < 5; i++) t[i] = tok_q[rd_idx + i];
    rd_idx += 5;
    got = {t[0][2:0], t[1][2:0], t[2][2:0], t[3][2:0], t[4][2:0]};
    exp = {3'd0, (c ? 3'd2 : 3'd1), 3'd3, (d ? 3'd2 : 3'd1), 3'd4};
    check({tag, "_seq"}, 32'(got), 32'(exp));
    check({tag, "_dec"}, {30'd0, (t[1] == 2), (t[3] == 2)}, {30'd0, c, d});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int base, n;
    bus_if.ev_valid = 1'b0;
    bus_if.ev_chan  = 1'b0;
    bus_if.ev_dir   = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("rst_lines", 32'(lines), 32'd0);
    check("rst_ready", 32'(bus_if.ev_ready), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(frame_done), 32'd0);
`ifdef AER_TIMEOUT_EN
    check("rst_tmo",   32'(timeout_err), 32'd0);
`endif

    // Single event, latency to Fs = 2 cycles after the accepting edge.
    push(1'b0, 1'b1);
    check("lat0", 32'(lines), 32'd0);
    cyc(1);
    check("lat1", 32'(lines), 32'd0);
    cyc(1);
    check("lat2", 32'(lines), 32'(LINE_FS));
    wait_done("t1_done", 1, 300);
    check_frame("t1", 1'b0, 1'b1);
    cyc(10);
    check("t1_once", done_cnt, 1);
    check("t1_idle", 32'(busy), 32'd0);

    // Stall Fs, fill the FIFO, inject a spurious Fe_ack.
    auto_en[0] = 1'b0;
    push(1'b1, 1'b0);
    wait_lines("t2_fs", LINE_FS, 20);
    push(1'b0, 1'b0);
    push(1'b0, 1'b1);
    push(1'b1, 1'b0);
    push(1'b1, 1'b1);
    check("t2_full", 32'(bus_if.ev_ready), 32'd0);
    push(1'b0, 1'b0);
    force_hi[4] = 1'b1;
    cyc(6);
    check("spur_fs_a", 32'(lines), 32'(LINE_FS));
    force_hi[4] = 1'b0;
    cyc(4);
    check("spur_fs_b", 32'(lines), 32'(LINE_FS));
    auto_en[0] = 1'b1;
    wait_done("t2_done", 6, 1500);
    check_frame("t2f0", 1'b1, 1'b0);
    check_frame("t2f1", 1'b0, 1'b0);
    check_frame("t2f2", 1'b0, 1'b1);
    check_frame("t2f3", 1'b1, 1'b0);
    check_frame("t2f4", 1'b1, 1'b1);
    cyc(150);
    check("t2_nolost", done_cnt, 6);
    check("t2_idle", 32'(busy), 32'd0);

    // Reset during the X0 high phase.
    push(1'b1, 1'b1);
    wait_lines("t3_x0", LINE_X0, 200);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    check("t3_lines", 32'(lines), 32'd0);
    check("t3_busy",  32'(busy), 32'd0);
    check("t3_ready", 32'(bus_if.ev_ready), 32'd1);
    reset = 1'b0;
    cyc(10);
    check("t3_nodone", done_cnt, 6);
    rd_idx = tok_q.size();
    push(1'b0, 1'b0);
    wait_done("t3_done", 7, 300);
    check_frame("t3", 1'b0, 1'b0);

    // Zero_ack stuck high before its SET.
    force_hi[1] = 1'b1;
    cyc(5);
    base = done_cnt;
    push(1'b0, 1'b1);
    wait_lines("t4_zero", LINE_ZERO, 200);
    cyc(1);
    check("t4_drop", 32'(lines), 32'd0);
    cyc(20);
    check("t4_hold", 32'(lines), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_nodone", done_cnt, base);
    force_hi[1] = 1'b0;
    wait_done("t4_done", base + 1, 300);
    check_frame("t4", 1'b0, 1'b1);

`ifdef AER_TIMEOUT_EN
    // Zero_ack never arrives: watchdog abandons the frame.
    cyc(5);
    base = done_cnt;
    auto_en[1] = 1'b0;
    push(1'b0, 1'b0);
    wait_lines("t5_zero", LINE_ZERO, 200);
    n = 0;
    while (lines == LINE_ZERO && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("t5_hicyc", n, TMO);
    check("t5_lines", 32'(lines), 32'd0);
    check("t5_err", 32'(timeout_err), 32'd1);
    cyc(10);
    check("t5_nodone", done_cnt, base);
    check("t5_idle", 32'(busy), 32'd0);
    auto_en[1] = 1'b1;
    rd_idx = tok_q.size();
    push(1'b1, 1'b0);
    wait_done("t5_done", base + 1, 300);
    check_frame("t5", 1'b1, 1'b0);
    check("t5_sticky", 32'(timeout_err), 32'd1);
`endif

    cyc(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aer_token_encoder.md
Name: aer_token_encoder

Overview:
- Synchronous AER transmitter that sits directly upstream of the asynchronous output decoder.
- Accepts channel events (channel 1/2, up/down) from the local logic through a small FIFO.
- Serialises each event as a 5-token return-to-zero frame on the Fs/Zero/One/X0/Fe lines, handshaking every token against the decoder's per-line acks.
- Acks arrive asynchronously, so they are synchronised internally.

Parameters:
- FIFO_DEPTH, 4: event queue entries; power of 2, ≥2.
- SYNC_STAGES, 2: flops in each ack synchroniser; ≥2.
- TIMEOUT_CYCLES, 1024: clk cycles allowed per handshake phase; used only with AER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- ev_valid  in  1  event offered
- ev_ready  out  1  FIFO can accept; equals !full
- ev_chan  in  1  0 = channel 1, 1 = channel 2
- ev_dir  in  1  0 = down, 1 = up
- Fs  out  1  frame-start token line
- Zero  out  1  data-0 token line
- One  out  1  data-1 token line
- X0  out  1  separator token line
- Fe  out  1  frame-end token line
- Fs_ack, Zero_ack, One_ack, X0_ack, Fe_ack  in  1 each  async acks from the decoder
- busy  out  1  frame in progress or FIFO non-empty
- frame_done  out  1  one-cycle pulse when a frame's Fe handshake completes
- timeout_err  out  1  sticky error flag; present only with AER_TIMEOUT_EN

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset values: all token lines 0, ev_ready 1, busy 0, frame_done 0, timeout_err 0. FIFO is emptied, FSM goes to IDLE, synchroniser flops are cleared to 0.
- FIFO push: on ev_valid && ev_ready, {ev_chan, ev_dir} is pushed. A push while full is impossible (ready is low).
- FIFO pop: occurs only in IDLE when the FIFO is non-empty. Push and pop in the same cycle are legal when not full.
- Frame token order (index k = 0..4): Fs, sel, X0, dir, Fe.
  - sel = Zero if chan = 0, One if chan = 1.
  - dir = Zero if dir = 0, One if dir = 1.
- The popped event is held in a frame register until Fe completes.
- FSM states:
  - IDLE: if FIFO is non-empty, pop, set k = 0, go to SET.
  - SET: drive the token-k line high (registered output), go to WAIT_HI.
  - WAIT_HI: wait for the synchronised ack of the token-k line to be 1. Then drop the line and go to WAIT_LO.
  - WAIT_LO: wait for that ack to be 0.
    - If k < 4: k++, go to SET.
    - If k = 4: pulse frame_done, go to IDLE.
- At most one token line is high in any cycle; lines are one-hot-or-zero.
- Acks not belonging to the current token are ignored.
- Latency: the first token (Fs) is high 2 cycles after the accepting edge when the FSM is idle and the FIFO is empty.
- Per-phase minimum: SYNC_STAGES + 1 cycles after the ack edge.
- Back-to-back frames: the next Fs rises no earlier than 2 cycles after frame_done.
- Reset mid-frame: the active line drops at the reset edge and the frame and FIFO contents are discarded. The downstream decoder is reset by its own reset.
- busy = (state != IDLE) || !empty.

Optional Feature:
- Macro: AER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_HI and WAIT_LO, cleared on every state change.
  - On reaching TIMEOUT_CYCLES, all lines drop, timeout_err is set (sticky until reset), the current frame is abandoned and the FSM returns to IDLE.
  - frame_done is not pulsed for an abandoned frame.
- Undefined: no counter and no timeout_err port. The FSM waits indefinitely.

Decomposition:
- Package aer_pkg holds:
  - FSM state enum {IDLE, SET, WAIT_HI, WAIT_LO}.
  - Token index constants TOK_FS=0, TOK_SEL=1, TOK_X0=2, TOK_DIR=3, TOK_FE=4.
  - A 5-bit one-hot token-line encoding shared with the decoder bench.
- Sub-module aer_ack_sync: a SYNC_STAGES-deep synchroniser, instantiated 5 times.
- The FIFO stays inline.

Test Plan:
- Single event chan=0, dir=1, with a bench decoder model acking 3 cycles after each line rises and falls → line sequence Fs, Zero, X0, One, Fe. frame_done fires once. Decoder model reports Ch1Up.
- Four events (0,0),(0,1),(1,0),(1,1) pushed back-to-back → ev_ready low after the 4th, with no push lost. Frames emitted in order. Decoder reports Ch1Down, Ch1Up, Ch2Down, Ch2Up.
- A spurious Fe_ack pulse injected during the Fs phase → ignored. Fs stays high until Fs_ack arrives.
- reset asserted during the WAIT_HI of token X0 → all lines 0 next cycle, busy 0, ev_ready 1. A new event afterwards produces a full clean frame.
- With AER_TIMEOUT_EN, TIMEOUT_CYCLES=16, Zero_ack held at 0 → line drops at cycle 16 of WAIT_HI, timeout_err=1 and stays set, no frame_done. The next event still transmits.
- Ack held high from before SET (stuck ack) → the FSM advances to WAIT_LO and holds there until the ack falls. The one-hot invariant is checked every cycle by assertion.
